// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the SRAM device-side responder.
// State encodings, counter width and default bus widths live here.
package sram_responder_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 18;
  localparam int CNT_W          = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WRITE
  } state_t;

  // Holds at CNT_MAX so an indefinitely long write pulse never wraps back below WR_MIN.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sram_resp_array.sv
// Word store behind the responder: synchronous write, registered read.
// Contents are not reset, so data survives a responder reset.
module sram_resp_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 262144,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sram_responder.sv
// sram_responder: cycle-accurate device end of the 16-bit SRAM port (read latency, write pulse width, turnaround).
// Define SRAM_RESPONDER_CHECK_EN to build in the sticky protocol checker driving proto_err.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DEPTH    = 262144,
  parameter int READ_LAT = 2,
  parameter int WR_MIN   = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_WE_N,
  output logic              rd_valid,
  output logic              wr_commit,
  output logic              proto_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] READ_LAT_C = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] WR_MIN_C   = CNT_W'(WR_MIN);

  state_t            state, state_n;
  logic [CNT_W-1:0]  rcnt, rcnt_n;
  logic [CNT_W-1:0]  wcnt, wcnt_n;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  addr_lat, addr_lat_n;
  logic [DATA_W-1:0] data_lat, data_lat_n;
  logic [DATA_W-1:0] rdata;
  logic [IDX_W-1:0]  idx;
  logic              addr_chg, start_wr, commit, rd_en, dq_oe;

  assign idx      = SRAM_ADDR[IDX_W-1:0];
  assign addr_chg = (SRAM_ADDR != addr_q);
  assign start_wr = !SRAM_WE_N && (state != WRITE);

  // WE_N gates the driver combinationally so DQ is released in the very cycle the controller takes the bus.
  assign dq_oe    = (state == RD_DRIVE) && SRAM_WE_N;
  assign SRAM_DQ  = dq_oe ? rdata : {DATA_W{1'bz}};
  assign rd_valid = dq_oe;

  always_comb begin
    state_n    = state;
    rcnt_n     = rcnt;
    wcnt_n     = wcnt;
    addr_lat_n = addr_lat;
    data_lat_n = data_lat;
    commit     = 1'b0;
    rd_en      = 1'b0;
    // A falling WE_N wins over a simultaneous address change so the first low cycle counts toward WR_MIN.
    if (start_wr) begin
      state_n    = WRITE;
      wcnt_n     = CNT_W'(1);
      addr_lat_n = idx;
      data_lat_n = SRAM_DQ;
    end else begin
      case (state)
        IDLE: begin
          state_n = RD_WAIT;
          rcnt_n  = CNT_W'(1);
        end
        RD_WAIT: begin
          if (addr_chg) begin
            rcnt_n = CNT_W'(1);
          end else if (rcnt == READ_LAT_C) begin
            state_n = RD_DRIVE;
            rd_en   = 1'b1;
          end else begin
            rcnt_n = rcnt + CNT_W'(1);
          end
        end
        RD_DRIVE: begin
          if (addr_chg) begin
            state_n = RD_WAIT;
            rcnt_n  = CNT_W'(1);
          end
        end
        WRITE: begin
          if (!SRAM_WE_N) begin
            wcnt_n     = sat_inc(wcnt);
            addr_lat_n = idx;
            data_lat_n = SRAM_DQ;
          end else begin
            commit  = (wcnt >= WR_MIN_C);
            state_n = RD_WAIT;
            rcnt_n  = CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rcnt      <= '0;
      wcnt      <= '0;
      addr_q    <= '0;
      addr_lat  <= '0;
      data_lat  <= '0;
      wr_commit <= 1'b0;
    end else begin
      state     <= state_n;
      rcnt      <= rcnt_n;
      wcnt      <= wcnt_n;
      addr_q    <= SRAM_ADDR;
      addr_lat  <= addr_lat_n;
      data_lat  <= data_lat_n;
      wr_commit <= commit;
    end
  end

  // The store is gated by rst so a write ending on a reset edge is dropped.
  sram_resp_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (commit && rst),
    .waddr(addr_lat),
    .wdata(data_lat),
    .re   (rd_en),
    .raddr(idx),
    .rdata(rdata)
  );

`ifdef SRAM_RESPONDER_CHECK_EN
  logic we_n_q, err_set, proto_err_q;

  assign err_set = (!SRAM_WE_N && !we_n_q && addr_chg)
                || ((state == WRITE) && SRAM_WE_N && (wcnt < WR_MIN_C))
                || (!SRAM_WE_N && $isunknown(SRAM_ADDR));

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_n_q      <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      we_n_q <= SRAM_WE_N;
      if (err_set) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with DEPTH=1024 so address wrap is reachable.
// DQ release is probed by driving 0 from the bench while the responder must be off the bus.
module tb_sram_responder;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 18;
`ifdef SRAM_RESPONDER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  wire  [DATA_W-1:0] sram_dq;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_we_n;
  logic              rd_valid, wr_commit, proto_err;
  logic              tb_oe;
  logic [DATA_W-1:0] tb_dq;

  int errors = 0;
  int checks = 0;

  assign sram_dq = tb_oe ? tb_dq : {DATA_W{1'bz}};

  always #5 clk = ~clk;

  sram_responder #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (1024),
    .READ_LAT(2),
    .WR_MIN  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SRAM_DQ  (sram_dq),
    .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(sram_we_n),
    .rd_valid (rd_valid),
    .wr_commit(wr_commit),
    .proto_err(proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [ADDR_W-1:0] a, input logic we_n,
                                input logic drive, input logic [DATA_W-1:0] d);
    sram_addr = a;
    sram_we_n = we_n;
    tb_oe     = drive;
    tb_dq     = d;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int n);
    apply_stimulus(a, 1'b0, 1'b1, d);
    repeat (n) tick();
    apply_stimulus(a, 1'b1, 1'b0, '0);
    tick();
  endtask

  task automatic read_expect(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp,
                             input string name);
    int waited = 0;
    apply_stimulus(a, 1'b1, 1'b0, '0);
    do begin
      tick();
      waited++;
    end while (rd_valid !== 1'b1 && waited < 8);
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_valid: rd_valid=%b after %0d cycles, required 1", name, rd_valid, waited);
    end
    checks++;
    if (sram_dq !== exp) begin
      errors++;
      $display("[TB] FAIL %s_data: dq=%h, required %h", name, sram_dq, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    apply_stimulus('0, 1'b1, 1'b0, '0);
    tick();
    tick();
    checks++;
    if ({rd_valid, wr_commit, proto_err} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, required 000", {rd_valid, wr_commit, proto_err});
    end
    tb_oe = 1'b1;
    #1;
    checks++;
    if (sram_dq !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_dq_release: dq=%h, required 0000", sram_dq);
    end
    tb_oe = 1'b0;
    rst   = 1'b1;
  endtask

  task automatic test_write_read();
    apply_stimulus(18'h00010, 1'b0, 1'b1, 16'h1234);
    tick();
    tick();
    apply_stimulus(18'h00010, 1'b1, 1'b0, '0);
    checks++;
    if (wr_commit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_early_commit: wr_commit=%b, required 0", wr_commit);
    end
    tick();
    checks++;
    if ({wr_commit, rd_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL wr_commit_pulse: {commit,valid}=%b, required 10", {wr_commit, rd_valid});
    end
    tick();
    checks++;
    if ({wr_commit, rd_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL wr_read_wait: {commit,valid}=%b, required 00", {wr_commit, rd_valid});
    end
    tick();
    checks++;
    if (rd_valid !== 1'b1 || sram_dq !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL wr_readback: valid=%b dq=%h, required 1 1234", rd_valid, sram_dq);
    end
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clean_write_proto: proto_err=%b, required 0", proto_err);
    end
  endtask

  task automatic test_short_pulse();
    do_write(18'h00020, 16'h7777, 2);
    apply_stimulus(18'h00020, 1'b0, 1'b1, 16'hBEEF);
    tick();
    apply_stimulus(18'h00020, 1'b1, 1'b0, '0);
    tick();
    checks++;
    if (wr_commit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_commit: wr_commit=%b, required 0", wr_commit);
    end
    checks++;
    if (proto_err !== CHK) begin
      errors++;
      $display("[TB] FAIL short_proto: proto_err=%b, required %b", proto_err, CHK);
    end
    read_expect(18'h00020, 16'h7777, "short_keep_old");
  endtask

  task automatic test_addr_restart();
    do_write(18'h00011, 16'h4321, 2);
    apply_stimulus(18'h00010, 1'b1, 1'b0, '0);
    tick();
    apply_stimulus(18'h00011, 1'b1, 1'b0, '0);
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_c0: rd_valid=%b, required 0", rd_valid);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_c1: rd_valid=%b, required 0", rd_valid);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b1 || sram_dq !== 16'h4321) begin
      errors++;
      $display("[TB] FAIL restart_c2: valid=%b dq=%h, required 1 4321", rd_valid, sram_dq);
    end
  endtask

  task automatic test_reset_mid_op();
    do_write(18'h00030, 16'h1111, 2);
    read_expect(18'h00030, 16'h1111, "pre_reset_read");
    rst = 1'b0;
    tick();
    tb_oe = 1'b1;
    tb_dq = 16'h0000;
    #1;
    checks++;
    if (sram_dq !== 16'h0000 || rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_read: dq=%h valid=%b, required 0000 0", sram_dq, rd_valid);
    end
    tb_oe = 1'b0;
    rst   = 1'b1;
    apply_stimulus(18'h00030, 1'b0, 1'b1, 16'h5555);
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({rd_valid, wr_commit, proto_err} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_mid_write: outputs=%b, required 000", {rd_valid, wr_commit, proto_err});
    end
    apply_stimulus(18'h00030, 1'b1, 1'b0, '0);
    tick();
    checks++;
    if (wr_commit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_drop_commit: wr_commit=%b, required 0", wr_commit);
    end
    rst = 1'b1;
    read_expect(18'h00030, 16'h1111, "reset_old_data");
  endtask

  task automatic test_wrap();
    do_write(18'h00005, 16'hA5A5, 2);
    read_expect(18'h00405, 16'hA5A5, "addr_wrap");
  endtask

  task automatic test_turnaround();
    apply_stimulus(18'h00405, 1'b0, 1'b1, 16'h0F0F);
    #1;
    checks++;
    if (sram_dq !== 16'h0F0F || rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL turnaround_release: dq=%h valid=%b, required 0f0f 0", sram_dq, rd_valid);
    end
    tick();
    tick();
    checks++;
    if (wr_commit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL turnaround_hold: wr_commit=%b, required 0", wr_commit);
    end
    apply_stimulus(18'h00405, 1'b1, 1'b0, '0);
    tick();
    checks++;
    if (wr_commit !== 1'b1) begin
      errors++;
      $display("[TB] FAIL turnaround_commit: wr_commit=%b, required 1", wr_commit);
    end
    tick();
    checks++;
    if (wr_commit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL commit_one_cycle: wr_commit=%b, required 0", wr_commit);
    end
    read_expect(18'h00405, 16'h0F0F, "turnaround_read");
  endtask

  task automatic test_long_pulse();
    logic seen = 1'b0;
    apply_stimulus(18'h00050, 1'b0, 1'b1, 16'h9999);
    repeat (17) begin
      tick();
      if (wr_commit === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL long_no_commit: commit seen=%b while WE_N low, required 0", seen);
    end
    apply_stimulus(18'h00050, 1'b1, 1'b0, '0);
    tick();
    checks++;
    if (wr_commit !== 1'b1) begin
      errors++;
      $display("[TB] FAIL long_saturate_commit: wr_commit=%b, required 1", wr_commit);
    end
    read_expect(18'h00050, 16'h9999, "long_read");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_short_pulse();
    test_addr_restart();
    test_reset_mid_op();
    test_wrap();
    test_turnaround();
    test_long_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
